mac_sat_pipe: RTL and testbench

Parametrised signed multiply-accumulate unit. It is the next-generation replacement for the fixed 10-bit MAC in the Stage 1 datapath. New features over the fixed unit:
- configurable operand and accumulator widths;
- configurable multiplier pipeline depth;
- per-sample accumulator restart (clr_in);
- selectable saturating or wrapping accumulation;
- sticky overflow flag.

Sustains one sample per clock. Feeds the generated-hardware dot-product chains.

---
 rtl/mac_pkg.sv | 44 ++++
 rtl/mac_sat_pipe_if.sv | 31 +++
 rtl/mac_acc_stage.sv | 55 +++++
 rtl/mac_sat_pipe.sv | 100 ++++++++++
 tb/tb_mac_sat_pipe.sv | 114 +++++++++++
 5 files changed

// File: rtl/mac_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mac_pkg
// Brief    : Shared widths and the saturating-add helper for mac_sat_pipe.
// Revision : 1.0
// ============================================================================
package mac_pkg;

    localparam int MAC_IN_W  = 10;
    localparam int MAC_ACC_W = 20;
    localparam int MAC_MAX_W = 64;

    typedef struct packed {
        logic                 ovf;
        logic [MAC_MAX_W-1:0] res;
    } sat_res_t;

    // Operands are sign-extended accumulator-range values; the 1-bit wider sum
    // is exact, and the range check against acc_w decides overflow.
    function automatic sat_res_t sat_add(
        input logic signed [MAC_MAX_W-1:0] base,
        input logic signed [MAC_MAX_W-1:0] prod,
        input int                          acc_w,
        input logic                        saturate
    );
        logic signed [MAC_MAX_W:0] sum;
        logic signed [MAC_MAX_W:0] hi;
        logic signed [MAC_MAX_W:0] lo;
        sat_res_t                  r;
        sum   = {base[MAC_MAX_W-1], base} + {prod[MAC_MAX_W-1], prod};
        hi    = (MAC_MAX_W+1)'(1) << (acc_w - 1);
        lo    = -hi;
        hi    = hi - (MAC_MAX_W+1)'(1);
        r.ovf = (sum > hi) || (sum < lo);
        if (saturate && r.ovf) begin
            r.res = sum[MAC_MAX_W] ? lo[MAC_MAX_W-1:0] : hi[MAC_MAX_W-1:0];
        end else begin
            r.res = sum[MAC_MAX_W-1:0];
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mac_sat_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : mac_sat_pipe_if
// Brief    : Sample/result bus of the MAC; slave modport is the MAC side.
// Revision : 1.0
// ============================================================================
interface mac_sat_pipe_if
    import mac_pkg::*;
#(
    parameter int IN_W  = MAC_IN_W,
    parameter int ACC_W = MAC_ACC_W
);
    logic signed [IN_W-1:0]  a;
    logic signed [IN_W-1:0]  b;
    logic                    valid_in;
    logic                    clr_in;
    logic signed [ACC_W-1:0] f;
    logic                    valid_out;
    logic                    ovf;

    modport master (
        output a, b, valid_in, clr_in,
        input  f, valid_out, ovf
    );

    modport slave (
        input  a, b, valid_in, clr_in,
        output f, valid_out, ovf
    );
endinterface
`default_nettype wire

// File: rtl/mac_acc_stage.sv
`default_nettype none
// ============================================================================
// Module   : mac_acc_stage
// Brief    : Accumulate register with saturate/wrap and sticky overflow.
// Revision : 1.0
// ============================================================================
module mac_acc_stage
    import mac_pkg::*;
#(
    parameter int ACC_W    = MAC_ACC_W,
    parameter int SATURATE = 1
) (
    input  wire logic                    clk,
    input  wire logic                    reset,
    input  wire logic                    valid_i,
    input  wire logic                    clr_i,
    input  wire logic signed [ACC_W-1:0] prod_i,
    output logic signed [ACC_W-1:0]      f_o,
    output logic                         valid_o,
    output logic                         ovf_o
);
    logic signed [ACC_W-1:0] f_q, f_d;
    logic                    ovf_q, ovf_d;
    logic                    valid_q;
    logic signed [ACC_W-1:0] w_base;
    sat_res_t                w_res;

    always_comb begin
        w_base = clr_i ? '0 : f_q;
        w_res  = sat_add(MAC_MAX_W'(w_base), MAC_MAX_W'(prod_i), ACC_W, SATURATE != 0);
        f_d    = f_q;
        ovf_d  = ovf_q;
        if (valid_i) begin
            f_d   = w_res.res[ACC_W-1:0];
            ovf_d = (clr_i ? 1'b0 : ovf_q) | w_res.ovf;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            f_q     <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            f_q     <= f_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_i;
        end
    end

    assign f_o     = f_q;
    assign ovf_o   = ovf_q;
    assign valid_o = valid_q;
endmodule
`default_nettype wire

// File: rtl/mac_sat_pipe.sv
`default_nettype none
// ============================================================================
// Module   : mac_sat_pipe
// Brief    : Pipelined signed multiply-accumulate, optional saturation.
// Revision : 1.0
// ============================================================================
module mac_sat_pipe
    import mac_pkg::*;
#(
    parameter int IN_W       = MAC_IN_W,
    parameter int ACC_W      = MAC_ACC_W,
    parameter int MUL_STAGES = 1,
    parameter int SATURATE   = 1
) (
    input  wire logic     clk,
    input  wire logic     reset,
    mac_sat_pipe_if.slave bus
);
    if (ACC_W < 2*IN_W) begin : g_bad_acc_w
        $error("mac_sat_pipe: ACC_W must be at least 2*IN_W");
    end
    if (ACC_W > MAC_MAX_W) begin : g_bad_acc_max
        $error("mac_sat_pipe: ACC_W exceeds MAC_MAX_W");
    end
    if (MUL_STAGES < 0 || MUL_STAGES > 3) begin : g_bad_stages
        $error("mac_sat_pipe: MUL_STAGES must be 0..3");
    end

    logic signed [IN_W-1:0]   a_q, b_q;
    logic                     clr_q, v0_q;
    logic signed [2*IN_W-1:0] w_mul;

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q   <= '0;
            b_q   <= '0;
            clr_q <= 1'b0;
            v0_q  <= 1'b0;
        end else begin
            v0_q <= bus.valid_in;
            if (bus.valid_in) begin
                a_q   <= bus.a;
                b_q   <= bus.b;
                clr_q <= bus.clr_in;
            end
        end
    end

    assign w_mul = (2*IN_W)'(a_q) * (2*IN_W)'(b_q);

    // The product is always registered once; MUL_STAGES adds stages on top.
    localparam int NREG = MUL_STAGES + 1;

    logic signed [ACC_W-1:0] w_prod_s [NREG+1];
    logic                    w_clr_s  [NREG+1];
    logic                    w_v_s    [NREG+1];

    assign w_prod_s[0] = ACC_W'(w_mul);
    assign w_clr_s[0]  = clr_q;
    assign w_v_s[0]    = v0_q;

    for (genvar i = 0; i < NREG; i++) begin : g_mul_pipe
        logic signed [ACC_W-1:0] prod_q;
        logic                    clr_q;
        logic                    v_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                prod_q <= '0;
                clr_q  <= 1'b0;
                v_q    <= 1'b0;
            end else begin
                v_q <= w_v_s[i];
                if (w_v_s[i]) begin
                    prod_q <= w_prod_s[i];
                    clr_q  <= w_clr_s[i];
                end
            end
        end

        assign w_prod_s[i+1] = prod_q;
        assign w_clr_s[i+1]  = clr_q;
        assign w_v_s[i+1]    = v_q;
    end

    mac_acc_stage #(
        .ACC_W    (ACC_W),
        .SATURATE (SATURATE)
    ) u_acc (
        .clk     (clk),
        .reset   (reset),
        .valid_i (w_v_s[NREG]),
        .clr_i   (w_clr_s[NREG]),
        .prod_i  (w_prod_s[NREG]),
        .f_o     (bus.f),
        .valid_o (bus.valid_out),
        .ovf_o   (bus.ovf)
    );
endmodule
`default_nettype wire

// File: tb/tb_mac_sat_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_sat_pipe
// Brief    : Directed vectors for saturating and wrapping MAC instances.
// Revision : 1.0
// ============================================================================
module tb_mac_sat_pipe;
    localparam int IN_W  = 10;
    localparam int ACC_W = 20;
    localparam int N     = 14;

    logic clk;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;

    mac_sat_pipe_if #(.IN_W(IN_W), .ACC_W(ACC_W)) sat_if ();
    mac_sat_pipe_if #(.IN_W(IN_W), .ACC_W(ACC_W)) wrap_if ();

    mac_sat_pipe #(.IN_W(IN_W), .ACC_W(ACC_W), .MUL_STAGES(1), .SATURATE(1)) dut_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (sat_if.slave)
    );

    mac_sat_pipe #(.IN_W(IN_W), .ACC_W(ACC_W), .MUL_STAGES(1), .SATURATE(0)) dut_wrap (
        .clk   (clk),
        .reset (reset),
        .bus   (wrap_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Row n drives inputs; expected outputs in row n belong to input row n-3.
    int t_v  [N] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 1, 0, 0, 0, 0};
    int t_a  [N] = '{3, -5, 7, 2, 9, 1, -512, -512, -512, 1, 0, 0, 0, 0};
    int t_b  [N] = '{4, 6, 7, 2, 9, -1, -512, -512, 1, 1, 0, 0, 0, 0};
    int t_c  [N] = '{1, 0, 1, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0};
    int e_vo [N] = '{0, 0, 0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 1, 0};
    int e_f  [N] = '{0, 0, 0, 12, -18, 49, 4, 4, 3, 262144, 524287, 523775, 1, 1};
    int e_ov [N] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0};
    int w_f  [N] = '{0, 0, 0, 12, -18, 49, 4, 4, 3, 262144, -524288, 523776, 1, 1};

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int v, input int a, input int b, input int c);
        sat_if.valid_in  = v[0];
        sat_if.a         = IN_W'(a);
        sat_if.b         = IN_W'(b);
        sat_if.clr_in    = c[0];
        wrap_if.valid_in = v[0];
        wrap_if.a        = IN_W'(a);
        wrap_if.b        = IN_W'(b);
        wrap_if.clr_in   = c[0];
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        sat_if.valid_in = 1'b0; sat_if.a = '0; sat_if.b = '0; sat_if.clr_in = 1'b0;
        wrap_if.valid_in = 1'b0; wrap_if.a = '0; wrap_if.b = '0; wrap_if.clr_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset f", int'(sat_if.f), 0);
        check("reset valid_out", int'(sat_if.valid_out), 0);
        check("reset ovf", int'(sat_if.ovf), 0);

        for (int i = 0; i < N; i++) begin
            step(t_v[i], t_a[i], t_b[i], t_c[i]);
            check($sformatf("sat valid_out row%0d", i), int'(sat_if.valid_out), e_vo[i]);
            check($sformatf("sat f row%0d", i), int'(sat_if.f), e_f[i]);
            check($sformatf("sat ovf row%0d", i), int'(sat_if.ovf), e_ov[i]);
            check($sformatf("wrap valid_out row%0d", i), int'(wrap_if.valid_out), e_vo[i]);
            check($sformatf("wrap f row%0d", i), int'(wrap_if.f), w_f[i]);
            check($sformatf("wrap ovf row%0d", i), int'(wrap_if.ovf), e_ov[i]);
        end

        // Two samples in flight, then a one-cycle reset must discard them.
        step(1, 5, 5, 1);
        step(1, 6, 6, 0);
        reset = 1'b1;
        step(0, 0, 0, 0);
        reset = 1'b0;
        check("post-reset f", int'(sat_if.f), 0);
        check("post-reset ovf", int'(sat_if.ovf), 0);
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 0);
            check($sformatf("post-reset valid_out c%0d", k), int'(sat_if.valid_out), 0);
            check($sformatf("post-reset f c%0d", k), int'(sat_if.f), 0);
        end

        step(1, 2, 3, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("fresh valid_out early", int'(sat_if.valid_out), 0);
        step(0, 0, 0, 0);
        check("fresh valid_out", int'(sat_if.valid_out), 1);
        check("fresh f", int'(sat_if.f), 6);
        check("fresh ovf", int'(sat_if.ovf), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
